// File: rtl/instr_ctrl.sv
// Multi-cycle instruction sequencer: fetches over a req/ack port, decodes the
// instruction register and steers the register file, ALU and data memory.
`timescale 1ns/1ps
module instr_ctrl #(
    parameter int                RWIDTH   = 6,
    parameter int                DWIDTH   = 32,
    parameter int                IMM_IN   = 15,
    parameter logic [DWIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [DWIDTH-1:0] imem_addr,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [DWIDTH-1:0] imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ack,
    output logic [RWIDTH-1:0] rs,
    output logic [RWIDTH-1:0] rt,
    output logic [RWIDTH-1:0] rd,
    output logic [IMM_IN-1:0] imm_in,
    output logic              muxsel1,
    output logic [3:0]        ALUopsel,
    output logic              we,
    output logic              wd_sel,
    output logic              halted,
    output logic              illegal
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    logic [2:0]        state;
    logic [DWIDTH-1:0] pc;
    logic [DWIDTH-1:0] ir;
    logic [DWIDTH-1:0] pc_plus4;
    logic [4:0]        op;
    logic [RWIDTH-1:0] fa;
    logic [RWIDTH-1:0] fb;
    logic [RWIDTH-1:0] fc;
    logic              is_rtype;
    logic              is_itype;
    logic              is_lw;
    logic              is_sw;
    logic              is_halt;
    logic              is_illegal;

    assign op       = ir[31:27];
    assign fa       = ir[26 -: RWIDTH];
    assign fb       = ir[20 -: RWIDTH];
    assign fc       = ir[14 -: RWIDTH];
    assign pc_plus4 = pc + DWIDTH'(4);

    always_comb begin
        is_rtype   = 1'b0;
        is_itype   = 1'b0;
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        if (op[4] == 1'b0)            is_rtype   = 1'b1;
        else if (op[3] == 1'b0)       is_itype   = 1'b1;
        else if (op == 5'b11000)      is_lw      = 1'b1;
        else if (op == 5'b11001)      is_sw      = 1'b1;
        else if (op == 5'b11111)      is_halt    = 1'b1;
        else                          is_illegal = 1'b1;
    end

    // Datapath steering is a pure function of IR, independent of state.
    always_comb begin
        rd       = fa;
        rs       = fb;
        rt       = is_sw ? fa : fc;
        imm_in   = ir[IMM_IN-1:0];
        muxsel1  = is_itype | is_lw | is_sw;
        ALUopsel = 4'b0000;
        if (is_rtype)      ALUopsel = op[3:0];
        else if (is_itype) ALUopsel = {1'b0, op[2:0]};
    end

    // Control strobes are forced low for as long as rst is held.
    assign imem_addr = pc;
    assign imem_req  = !rst && (state == S_FETCH);
    assign dmem_req  = !rst && (state == S_MEM);
    assign dmem_we   = !rst && (state == S_MEM) && is_sw;
    assign we        = !rst && (state == S_WB) && (rd != '0);
    assign wd_sel    = !rst && (state == S_WB) && is_lw;
    assign halted    = !rst && (state == S_HALT);
    assign illegal   = !rst && (state == S_DECODE) && is_illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_halt) begin
                        state <= S_HALT;
                    end else if (is_illegal) begin
                        pc    <= pc_plus4;
                        state <= S_FETCH;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state <= (is_lw || is_sw) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        if (is_sw) begin
                            pc    <= pc_plus4;
                            state <= S_FETCH;
                        end else begin
                            state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    pc    <= pc_plus4;
                    state <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_ctrl.sv
// Bench for instr_ctrl: scenario tasks with a writeback scoreboard queue,
// plus a second instance that starts at the top of the address space.
`timescale 1ns/1ps
module tb_instr_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_req, dmem_req, dmem_we, muxsel1, we, wd_sel, halted, illegal;
    logic [5:0]  rs, rt, rd;
    logic [14:0] imm_in;
    logic [3:0]  ALUopsel;

    logic        w_imem_ack = 1'b0;
    logic [31:0] w_imem_rdata = '0;
    logic        w_dmem_ack = 1'b0;
    logic [31:0] w_imem_addr;
    logic        w_imem_req, w_dmem_req, w_dmem_we, w_muxsel1, w_we, w_wd_sel, w_halted, w_illegal;
    logic [5:0]  w_rs, w_rt, w_rd;
    logic [14:0] w_imm_in;
    logic [3:0]  w_ALUopsel;

    typedef struct packed {
        logic [5:0] rd;
        logic       wd_sel;
    } wb_exp_t;

    wb_exp_t     wb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc = '0;

    instr_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rs(rs), .rt(rt), .rd(rd), .imm_in(imm_in), .muxsel1(muxsel1), .ALUopsel(ALUopsel),
        .we(we), .wd_sel(wd_sel), .halted(halted), .illegal(illegal)
    );

    instr_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_addr(w_imem_addr), .imem_req(w_imem_req), .imem_ack(w_imem_ack), .imem_rdata(w_imem_rdata),
        .dmem_req(w_dmem_req), .dmem_we(w_dmem_we), .dmem_ack(w_dmem_ack),
        .rs(w_rs), .rt(w_rt), .rd(w_rd), .imm_in(w_imm_in), .muxsel1(w_muxsel1), .ALUopsel(w_ALUopsel),
        .we(w_we), .wd_sel(w_wd_sel), .halted(w_halted), .illegal(w_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // At most one of the three request/enable strobes may be high in a cycle.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((int'(we) + int'(imem_req) + int'(dmem_req)) > 1) begin
                errors++;
                $display("FAIL exclusive_strobes we=%b imem_req=%b dmem_req=%b required at most one high",
                         we, imem_req, dmem_req);
            end
        end
    end

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [5:0] fa,
                                        input logic [5:0] fb, input logic [14:0] low);
        return {op, fa, fb, low};
    endfunction

    // Waits (bounded) for a fetch request, then returns one instruction.
    task automatic do_fetch(input logic [31:0] instr, input string name);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (imem_req !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_fetch_timeout imem_req=%b required 1", name, imem_req);
        end
        imem_rdata = instr;
        imem_ack   = 1'b1;
        @(negedge clk);
        imem_ack   = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({imem_req, dmem_req, dmem_we, we, wd_sel, halted, illegal} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b required 0000000",
                     {imem_req, dmem_req, dmem_we, we, wd_sel, halted, illegal});
        end
        checks++;
        if (imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc got %h required 00000000", imem_addr);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold_imem_req got %b required 0", imem_req);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_release_fetch req=%b addr=%h required 1 00000000", imem_req, imem_addr);
        end
        @(negedge clk);
        exp_pc = 32'h0;
    endtask

    task automatic test_rtype();
        int we_cycles = 0;
        int first = -1;
        wb_exp_t e;
        checks++;
        if (imem_addr !== exp_pc) begin
            errors++;
            $display("FAIL rtype_fetch_addr got %h required %h", imem_addr, exp_pc);
        end
        wb_q.push_back('{rd: 6'd3, wd_sel: 1'b0});
        do_fetch(enc(5'b00010, 6'd3, 6'd1, {6'd2, 9'd0}), "rtype");
        checks++;
        if (rs !== 6'd1 || rt !== 6'd2 || rd !== 6'd3) begin
            errors++;
            $display("FAIL rtype_regs rs=%0d rt=%0d rd=%0d required 1 2 3", rs, rt, rd);
        end
        checks++;
        if (muxsel1 !== 1'b0 || ALUopsel !== 4'b0010) begin
            errors++;
            $display("FAIL rtype_alu muxsel1=%b ALUopsel=%b required 0 0010", muxsel1, ALUopsel);
        end
        for (int i = 1; i <= 6; i++) begin
            if (i > 1) @(negedge clk);
            if (we === 1'b1) begin
                we_cycles++;
                if (first < 0) first = i;
                checks++;
                if (wb_q.size() == 0) begin
                    errors++;
                    $display("FAIL rtype_unexpected_write rd=%0d required no write", rd);
                end else begin
                    e = wb_q.pop_front();
                    if (rd !== e.rd || wd_sel !== e.wd_sel) begin
                        errors++;
                        $display("FAIL rtype_wb rd=%0d wd_sel=%b required %0d %b", rd, wd_sel, e.rd, e.wd_sel);
                    end
                end
            end
        end
        checks++;
        if (we_cycles != 1 || first != 3) begin
            errors++;
            $display("FAIL rtype_we_timing cycles=%0d first=%0d required 1 3", we_cycles, first);
        end
        checks++;
        if (imem_addr !== exp_pc + 32'd4) begin
            errors++;
            $display("FAIL rtype_next_pc got %h required %h", imem_addr, exp_pc + 32'd4);
        end
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic test_lw();
        int  req_cycles = 0;
        logic saw_we_store = 1'b0;
        wb_exp_t e;
        wb_q.push_back('{rd: 6'd5, wd_sel: 1'b1});
        do_fetch(enc(5'b11000, 6'd5, 6'd1, 15'h7FFC), "lw");
        checks++;
        if (muxsel1 !== 1'b1 || ALUopsel !== 4'b0000 || imm_in !== 15'h7FFC || rd !== 6'd5 || rs !== 6'd1) begin
            errors++;
            $display("FAIL lw_decode muxsel1=%b alu=%b imm=%h rd=%0d rs=%0d required 1 0000 7ffc 5 1",
                     muxsel1, ALUopsel, imm_in, rd, rs);
        end
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL lw_exec_dmem_req got %b required 0", dmem_req);
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (dmem_req === 1'b1) req_cycles++;
            if (dmem_we !== 1'b0) saw_we_store = 1'b1;
            imem_ack   = 1'b1;
            imem_rdata = 32'hFFFF_FFFF;
            if (k == 3) dmem_ack = 1'b1;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        checks++;
        if (req_cycles != 4 || saw_we_store) begin
            errors++;
            $display("FAIL lw_mem_hold req_cycles=%0d dmem_we_seen=%b required 4 0", req_cycles, saw_we_store);
        end
        checks++;
        if (we !== 1'b1 || wb_q.size() == 0) begin
            errors++;
            $display("FAIL lw_wb_we got %b queued=%0d required 1", we, wb_q.size());
        end else begin
            e = wb_q.pop_front();
            checks++;
            if (rd !== e.rd || wd_sel !== e.wd_sel) begin
                errors++;
                $display("FAIL lw_wb rd=%0d wd_sel=%b required %0d %b", rd, wd_sel, e.rd, e.wd_sel);
            end
        end
        @(negedge clk);
        checks++;
        if (imem_addr !== exp_pc + 32'd4 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL lw_next_pc got %h req=%b required %h 1", imem_addr, imem_req, exp_pc + 32'd4);
        end
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic test_sw();
        logic saw_we = 1'b0;
        do_fetch(enc(5'b11001, 6'd7, 6'd2, {6'd4, 9'd0}), "sw");
        if (we !== 1'b0) saw_we = 1'b1;
        checks++;
        if (rt !== 6'd7 || muxsel1 !== 1'b1 || ALUopsel !== 4'b0000) begin
            errors++;
            $display("FAIL sw_decode rt=%0d muxsel1=%b alu=%b required 7 1 0000", rt, muxsel1, ALUopsel);
        end
        @(negedge clk);
        if (we !== 1'b0) saw_we = 1'b1;
        @(negedge clk);
        if (we !== 1'b0) saw_we = 1'b1;
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
            errors++;
            $display("FAIL sw_mem dmem_req=%b dmem_we=%b required 1 1", dmem_req, dmem_we);
        end
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        if (we !== 1'b0) saw_we = 1'b1;
        checks++;
        if (saw_we) begin
            errors++;
            $display("FAIL sw_no_write we_seen=%b required 0", saw_we);
        end
        checks++;
        if (imem_addr !== exp_pc + 32'd4 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL sw_next_pc got %h req=%b required %h 1", imem_addr, imem_req, exp_pc + 32'd4);
        end
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic test_illegal();
        int pulses = 0;
        logic bad_strobe = 1'b0;
        do_fetch(enc(5'b11010, 6'd1, 6'd2, 15'd0), "illegal");
        checks++;
        if (illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_decode got %b required 1", illegal);
        end
        for (int i = 0; i < 4; i++) begin
            if (illegal === 1'b1) pulses++;
            if (we !== 1'b0 || dmem_req !== 1'b0) bad_strobe = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (pulses != 1 || bad_strobe) begin
            errors++;
            $display("FAIL illegal_pulse cycles=%0d strobe_seen=%b required 1 0", pulses, bad_strobe);
        end
        checks++;
        if (imem_addr !== exp_pc + 32'd4) begin
            errors++;
            $display("FAIL illegal_next_pc got %h required %h", imem_addr, exp_pc + 32'd4);
        end
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic test_r0_write();
        int we_cycles = 0;
        do_fetch(enc(5'b00001, 6'd0, 6'd4, {6'd5, 9'd0}), "r0");
        for (int i = 0; i < 5; i++) begin
            if (we === 1'b1) we_cycles++;
            @(negedge clk);
        end
        checks++;
        if (we_cycles != 0) begin
            errors++;
            $display("FAIL r0_we cycles=%0d required 0", we_cycles);
        end
        checks++;
        if (imem_addr !== exp_pc + 32'd4) begin
            errors++;
            $display("FAIL r0_next_pc got %h required %h", imem_addr, exp_pc + 32'd4);
        end
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic test_halt();
        logic leak = 1'b0;
        int   halt_cycles = 0;
        do_fetch(enc(5'b11111, 6'd0, 6'd0, 15'd0), "halt");
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_decode_early got %b required 0", halted);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            imem_ack = 1'b1;
            if (halted === 1'b1) halt_cycles++;
            if (imem_req !== 1'b0 || dmem_req !== 1'b0 || we !== 1'b0) leak = 1'b1;
        end
        imem_ack = 1'b0;
        checks++;
        if (halt_cycles != 6 || leak) begin
            errors++;
            $display("FAIL halt_hold halted_cycles=%0d strobe_seen=%b required 6 0", halt_cycles, leak);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (halted !== 1'b0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_halt halted=%b addr=%h required 0 00000000", halted, imem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL async_reset_fetch imem_req=%b required 1", imem_req);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_fetch imem_req=%b required 0", imem_req);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_pc = 32'h0;
    endtask

    task automatic test_reset_mid_store();
        do_fetch(enc(5'b11001, 6'd9, 6'd1, 15'd0), "reset_sw");
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_sw_mem dmem_req=%b required 1", dmem_req);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || we !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_mem req=%b dmem_we=%b we=%b required 0 0 0", dmem_req, dmem_we, we);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_sw_restart addr=%h req=%b required 00000000 1", imem_addr, imem_req);
        end
        exp_pc = 32'h0;
    endtask

    task automatic test_wrap();
        checks++;
        if (w_imem_addr !== 32'hFFFF_FFFC || w_imem_req !== 1'b1) begin
            errors++;
            $display("FAIL wrap_start addr=%h req=%b required fffffffc 1", w_imem_addr, w_imem_req);
        end
        w_imem_rdata = enc(5'b00000, 6'd1, 6'd2, {6'd3, 9'd0});
        w_imem_ack   = 1'b1;
        @(negedge clk);
        w_imem_ack   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (w_we !== 1'b1 || w_rd !== 6'd1) begin
            errors++;
            $display("FAIL wrap_wb we=%b rd=%0d required 1 1", w_we, w_rd);
        end
        @(negedge clk);
        checks++;
        if (w_imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_next_pc got %h required 00000000", w_imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw();
        test_sw();
        test_illegal();
        test_r0_write();
        test_halt();
        test_async_reset();
        test_reset_mid_store();
        test_wrap();
        checks++;
        if (wb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d required 0", wb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
